// File: rtl/dot_mmio_pkg.sv
// Shared constants and entry type for the dot MMIO window.
// Used by the dot update queue and its FIFO.
package dot_mmio_pkg;

  localparam int unsigned X_BASE   = 10240;
  localparam int unsigned Y_BASE   = 12288;
  localparam int unsigned N_DOTS   = 2048;
  localparam int unsigned ID_W     = 11;
  localparam int unsigned LOC_W    = 32;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned RNG_ADDR = 9990;

  typedef struct packed {
    logic             is_y;
    logic [ID_W-1:0]  id;
    logic [LOC_W-1:0] loc;
  } dot_entry_t;

endpackage

// File: rtl/dot_update_queue_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// The upd strobe rewrites the most recently written entry in place.
module sync_fifo
  import dot_mmio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             upd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    tail;
  logic [AW:0]      count_nx;

  assign rdata = mem[rptr];
  assign tail  = wptr - AW'(1);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + (AW+1)'(1);
      2'b01:   count_nx = count - (AW+1)'(1);
      default: count_nx = count;
    endcase
  end

  // Storage array: append at the tail or rewrite the last entry.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= wdata;
    end else if (upd) begin
      mem[tail] <= wdata;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

endmodule

// File: rtl/dot_update_queue.sv
// Buffers dot MMIO stores and drains them during vertical blanking.
// Optional store coalescing: DOT_QUEUE_COALESCE_EN.
module dot_update_queue
  import dot_mmio_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned X_BASE = 10240,
  parameter int unsigned Y_BASE = 12288,
  parameter int unsigned N_DOTS = 2048,
  parameter int unsigned ID_W   = 11,
  parameter int unsigned LOC_W  = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned EW    = 1 + ID_W + LOC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wren,
  input  logic [31:0]      address_dmem,
  input  logic [31:0]      data,
  input  logic             vblank,
  output logic             dotWren,
  output logic             is_Yloc,
  output logic [ID_W-1:0]  dotID,
  output logic [LOC_W-1:0] dotLoc,
  output logic             q_full,
  output logic             q_empty,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  typedef struct packed {
    logic             is_y;
    logic [ID_W-1:0]  id;
    logic [LOC_W-1:0] loc;
  } entry_t;

  logic             hit_x;
  logic             hit_y;
  logic             in_range;
  logic [31:0]      base;
  logic [31:0]      off;
  logic [ID_W-1:0]  id;
  logic             valid;
  logic             drop_rng;
  logic             drop_full;
  logic             pop;
  logic             push;
  logic             coal;
  entry_t           went;
  entry_t           head;
  logic [AW:0]      count;

  // Window decode of the store address.
  always_comb begin
    hit_x    = (address_dmem >= 32'(X_BASE))
             && (address_dmem < 32'(Y_BASE));
    hit_y    = (address_dmem >= 32'(Y_BASE));
    base     = hit_y ? 32'(Y_BASE) : 32'(X_BASE);
    off      = address_dmem - base;
    in_range = (off < 32'(N_DOTS));
    id       = off[ID_W-1:0];
  end

  assign valid    = wren & (hit_x | hit_y) & in_range;
  assign drop_rng = wren & (hit_x | hit_y) & ~in_range;
  assign pop      = vblank & ~q_empty;

  assign went.is_y = hit_y;
  assign went.id   = id;
  assign went.loc  = LOC_W'(data);

`ifdef DOT_QUEUE_COALESCE_EN
  logic [ID_W:0] last_key;

  assign coal = valid & ~q_empty
              & (last_key == {hit_y, id})
              & ~(pop & (count == (AW+1)'(1)));

  // Key of the newest entry, which is always the FIFO tail.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_key <= '0;
    end else if (push) begin
      last_key <= {hit_y, id};
    end
  end
`else
  logic unused;
  assign unused = ^count;
  assign coal   = 1'b0;
`endif

  assign push      = valid & ~coal & (~q_full | pop);
  assign drop_full = valid & ~coal & ~push;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .upd   (coal),
    .wdata (went),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (count)
  );

  // Registered write port toward the VGA dot tables.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dotWren <= 1'b0;
      is_Yloc <= 1'b0;
      dotID   <= '0;
      dotLoc  <= '0;
    end else begin
      dotWren <= pop;
      if (pop) begin
        is_Yloc <= head.is_y;
        dotID   <= head.id;
        dotLoc  <= head.loc;
      end
    end
  end

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop_full) overflow <= 1'b1;
      if ((drop_full | drop_rng) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dot_update_queue.sv
// Self-checking bench for dot_update_queue.
// Directed tables, corner sequences and a random run against a queue model.
`timescale 1ns/1ps
module tb_dot_update_queue;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        vblank = 1'b0;
  logic        dotWren;
  logic        is_Yloc;
  logic [10:0] dotID;
  logic [31:0] dotLoc;
  logic        q_full;
  logic        q_empty;
  logic        overflow;
  logic [15:0] drop_count;

  dot_update_queue dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .vblank       (vblank),
    .dotWren      (dotWren),
    .is_Yloc      (is_Yloc),
    .dotID        (dotID),
    .dotLoc       (dotLoc),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic vb);
    wren = w;
    address_dmem = a;
    data = d;
    vblank = vb;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    wren = 0;
    vblank = 0;
    address_dmem = 0;
    data = 0;
    @(negedge clock);
    reset = 0;
    #2;
    chk("rst_wren", 32'(dotWren), 0);
    chk("rst_empty", 32'(q_empty), 1);
    chk("rst_full", 32'(q_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_loc", dotLoc, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  // Behavioural model: a queue of pending dot writes.
  typedef struct {
    bit          y;
    int unsigned id;
    logic [31:0] loc;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf;
  int unsigned m_drop;
  bit          m_wren;
  bit          m_y;
  int unsigned m_id;
  logic [31:0] m_loc;

  function automatic void model_clear();
    mq.delete();
    m_ovf = 0;
    m_drop = 0;
    m_wren = 0;
    m_y = 0;
    m_id = 0;
    m_loc = 0;
  endfunction

  function automatic void model_edge(bit w, logic [31:0] a,
                                     logic [31:0] d, bit vb);
    bit hit = 0;
    bit y = 0;
    longint off = 0;
    bit do_pop;
    ent_t head;
    ent_t e;
    bit coal = 0;
    do_pop = vb && (mq.size() > 0);
    if (do_pop) head = mq[0];
    if (w && a >= 12288) begin
      hit = 1; y = 1; off = longint'(a) - 12288;
    end else if (w && a >= 10240) begin
      hit = 1; y = 0; off = longint'(a) - 10240;
    end
    if (hit && off >= 2048) begin
      if (m_drop < 16'hFFFF) m_drop++;
      hit = 0;
    end
`ifdef DOT_QUEUE_COALESCE_EN
    if (hit && mq.size() > 0 && mq[$].y == y
        && mq[$].id == int'(off)
        && !(do_pop && mq.size() == 1)) begin
      mq[$].loc = d;
      coal = 1;
    end
`endif
    if (do_pop) void'(mq.pop_front());
    if (hit && !coal) begin
      if (mq.size() + (do_pop ? 1 : 0) < DEPTH || do_pop) begin
        e.y = y; e.id = int'(off); e.loc = d;
        mq.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drop < 16'hFFFF) m_drop++;
      end
    end
    m_wren = do_pop;
    if (do_pop) begin
      m_y = head.y; m_id = head.id; m_loc = head.loc;
    end
  endfunction

  task automatic mstep(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic vb);
    model_edge(w, a, d, vb);
    step(w, a, d, vb);
    chk("r_wren", 32'(dotWren), 32'(m_wren));
    chk("r_isy", 32'(is_Yloc), 32'(m_y));
    chk("r_id", 32'(dotID), m_id);
    chk("r_loc", dotLoc, m_loc);
    chk("r_full", 32'(q_full), 32'(mq.size() == DEPTH));
    chk("r_empty", 32'(q_empty), 32'(mq.size() == 0));
    chk("r_ovf", 32'(overflow), 32'(m_ovf));
    chk("r_drop", 32'(drop_count), m_drop);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        vb;
    logic        ew;
    logic        ey;
    logic [10:0] eid;
    logic [31:0] eloc;
    logic        ee;
  } vec_t;

  vec_t        tbl[10];
  int          n;
  logic [31:0] got[$];

  initial begin
    tbl[0] = '{1, 10245, 37, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 1, 0, 5, 37, 1};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 12288, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 10240, 2, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 12300, 3, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 1, 1, 0, 0, 2, 0};
    tbl[8] = '{0, 0, 0, 1, 1, 1, 12, 3, 1};
    tbl[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].vb);
      chk($sformatf("t%0d_wren", i), 32'(dotWren), 32'(tbl[i].ew));
      if (tbl[i].ew) begin
        chk($sformatf("t%0d_isy", i), 32'(is_Yloc), 32'(tbl[i].ey));
        chk($sformatf("t%0d_id", i), 32'(dotID), 32'(tbl[i].eid));
        chk($sformatf("t%0d_loc", i), dotLoc, tbl[i].eloc);
      end
      chk($sformatf("t%0d_empty", i), 32'(q_empty), 32'(tbl[i].ee));
    end

    // Fill past capacity, then drain.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, 32'(10240 + i), 32'(100 + i), 0);
      if (i == 15) chk("fill_full16", 32'(q_full), 1);
      if (i == 15) chk("fill_ovf16", 32'(overflow), 0);
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_count), 1);
    chk("ovf_full", 32'(q_full), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      if (dotWren) begin
        chk("drain_loc", dotLoc, 32'(100 + n));
        n++;
      end
    end
    chk("drain_cnt", 32'(n), 16);
    chk("drain_empty", 32'(q_empty), 1);

    // Out-of-range and out-of-window stores.
    step(1, 14336, 5, 0);
    chk("oor_drop", 32'(drop_count), 2);
    chk("oor_empty", 32'(q_empty), 1);
    step(1, 500, 5, 0);
    chk("ign_drop", 32'(drop_count), 2);
    step(1, 9990, 5, 0);
    chk("rng_drop", 32'(drop_count), 2);
    chk("ign_empty", 32'(q_empty), 1);
    chk("ign_ovf", 32'(overflow), 1);

    // Push at full on a pop edge, then reset mid-drain.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'(10240 + i), 32'(i), 0);
    chk("pp_full0", 32'(q_full), 1);
    step(1, 10340, 77, 1);
    chk("pp_full", 32'(q_full), 1);
    chk("pp_wren", 32'(dotWren), 1);
    chk("pp_loc", dotLoc, 0);
    chk("pp_drop", 32'(drop_count), 0);
    chk("pp_ovf", 32'(overflow), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("md_wren", 32'(dotWren), 1);
    @(negedge clock);
    reset = 0;
    #1;
    chk("mr_wren", 32'(dotWren), 0);
    chk("mr_empty", 32'(q_empty), 1);
    chk("mr_full", 32'(q_full), 0);
    @(posedge clock);
    #1;
    reset = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      if (dotWren) n++;
    end
    chk("mr_nowr", 32'(n), 0);

    // Repeated store to the same dot.
    do_reset();
    step(1, 10241, 4, 0);
    step(1, 10241, 9, 0);
    got.delete();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      if (dotWren) got.push_back(dotLoc);
    end
`ifdef DOT_QUEUE_COALESCE_EN
    chk("co_cnt", 32'(got.size()), 1);
    if (got.size() > 0) chk("co_v0", got[0], 9);
`else
    chk("co_cnt", 32'(got.size()), 2);
    if (got.size() > 1) begin
      chk("co_v0", got[0], 4);
      chk("co_v1", got[1], 9);
    end
`endif

    // Random traffic against the model.
    do_reset();
    model_clear();
    for (int i = 0; i < 1500; i++) begin
      int k;
      logic [31:0] a;
      logic w;
      k = int'($urandom_range(0, 9));
      w = 1;
      unique case (k)
        0, 1, 2, 3: a = 32'(10240 + $urandom_range(0, 7));
        4:          a = 32'(12288 + $urandom_range(0, 3));
        5:          a = ($urandom_range(0, 1) != 0) ? 32'd12287
                                                    : 32'd14335;
        6:          a = 32'(14336 + $urandom_range(0, 100));
        7:          a = ($urandom_range(0, 1) != 0) ? 32'd500
                                                    : 32'd9990;
        default: begin
          a = 32'($urandom);
          w = 0;
        end
      endcase
      mstep(w, a, $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
